// File: rtl/datapath_pkg.sv
// Shared definitions for datapath consumers: default word width, accumulator sizing
// and saturation bounds, plus the output-slot state type.
package datapath_pkg;

    localparam int DP_N = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Four guard bits above the word width absorb short reductions without wrap.
    function automatic int acc_width(input int n);
        return n + 4;
    endfunction

    function automatic longint sat_max(input int acc_w);
        return (longint'(1) << (acc_w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int acc_w);
        return -(longint'(1) << (acc_w - 1));
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// PIPE-deep valid shift register that re-aligns an issue-side valid with a
// fixed-latency pipeline; any_valid flags a valid anywhere in flight.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic out_valid,
    output logic any_valid
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // The cast drops the oldest bit, which also covers DEPTH == 1.
    always_comb begin
        sr_d = DEPTH'({sr_q, in_valid});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign out_valid = sr_q[DEPTH-1];
    assign any_valid = |sr_q;

endmodule

// File: rtl/datapath_result_accum.sv
// Sums LEN datapath results per window into a one-deep ready/valid output slot.
// Build option DATAPATH_ACC_SAT_EN: saturating adds with overflow report (wrap otherwise).
module datapath_result_accum
    import datapath_pkg::*;
#(
    parameter int N     = DP_N,
    parameter int PIPE  = 2,
    parameter int LEN   = 32,
    parameter int ACC_W = acc_width(DP_N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic signed [N-1:0]     Y,
    input  logic                    co,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_co,
    output logic                    out_ovf,
    output logic                    err_overrun,
    output logic                    busy
);

    localparam int               CNT_W    = $clog2(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    logic res_valid;
    logic dly_busy;

    valid_delay_line #(
        .DEPTH(PIPE)
    ) u_valid_delay_line (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_valid),
        .out_valid (res_valid),
        .any_valid (dly_busy)
    );

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    co_acc_q, co_acc_d;
    logic                    ovf_acc_q, ovf_acc_d;
    slot_state_t             state_q, state_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_co_q, out_co_d;
    logic                    out_ovf_q, out_ovf_d;
    logic                    err_overrun_q, err_overrun_d;

    logic signed [ACC_W-1:0] y_ext;
    logic signed [ACC_W-1:0] add_sum;
    logic                    add_clamp;
    logic                    win_end;

    assign y_ext = {{(ACC_W - N){Y[N-1]}}, Y};

`ifdef DATAPATH_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] add_wide;

    // One extra bit exposes signed overflow as a disagreement of the top two bits.
    always_comb begin
        add_wide  = {acc_q[ACC_W-1], acc_q} + {y_ext[ACC_W-1], y_ext};
        add_clamp = add_wide[ACC_W] != add_wide[ACC_W-1];
        if (!add_clamp) begin
            add_sum = add_wide[ACC_W-1:0];
        end else if (add_wide[ACC_W]) begin
            add_sum = ACC_MIN;
        end else begin
            add_sum = ACC_MAX;
        end
    end
`else
    assign add_sum   = acc_q + y_ext;
    assign add_clamp = 1'b0;
`endif

    assign win_end = res_valid && (cnt_q == CNT_LAST);

    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        co_acc_d      = co_acc_q;
        ovf_acc_d     = ovf_acc_q;
        state_d       = state_q;
        out_data_d    = out_data_q;
        out_co_d      = out_co_q;
        out_ovf_d     = out_ovf_q;
        err_overrun_d = err_overrun_q;

        if (win_end) begin
            acc_d     = '0;
            cnt_d     = '0;
            co_acc_d  = 1'b0;
            ovf_acc_d = 1'b0;
        end else if (res_valid) begin
            acc_d     = add_sum;
            cnt_d     = cnt_q + 1'b1;
            co_acc_d  = co_acc_q | co;
            ovf_acc_d = ovf_acc_q | add_clamp;
        end

        // The datapath cannot stall, so a full slot without a handshake drops the new sum.
        case (state_q)
            SLOT_EMPTY: begin
                if (win_end) begin
                    state_d    = SLOT_FULL;
                    out_data_d = add_sum;
                    out_co_d   = co_acc_q | co;
                    out_ovf_d  = ovf_acc_q | add_clamp;
                end
            end
            SLOT_FULL: begin
                if (out_ready) begin
                    if (win_end) begin
                        out_data_d = add_sum;
                        out_co_d   = co_acc_q | co;
                        out_ovf_d  = ovf_acc_q | add_clamp;
                    end else begin
                        state_d = SLOT_EMPTY;
                    end
                end else if (win_end) begin
                    err_overrun_d = 1'b1;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            co_acc_q      <= 1'b0;
            ovf_acc_q     <= 1'b0;
            state_q       <= SLOT_EMPTY;
            out_data_q    <= '0;
            out_co_q      <= 1'b0;
            out_ovf_q     <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            co_acc_q      <= co_acc_d;
            ovf_acc_q     <= ovf_acc_d;
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            out_co_q      <= out_co_d;
            out_ovf_q     <= out_ovf_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign out_valid   = (state_q == SLOT_FULL);
    assign out_data    = out_data_q;
    assign out_co      = out_co_q;
    assign out_ovf     = out_ovf_q;
    assign err_overrun = err_overrun_q;
    assign busy        = (cnt_q != '0) || dly_busy;

endmodule

// File: tb/tb_datapath_result_accum.sv
// Bench for datapath_result_accum: two instances (LEN=4 and LEN=32) share one
// directed stimulus; a window-level model is checked every cycle plus literal pins.
module tb_datapath_result_accum;

    localparam int N     = 16;
    localparam int PIPE  = 2;
    localparam int ACC_W = 20;
    localparam int LEN_A = 4;
    localparam int LEN_B = 32;
    localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    issue_valid = 1'b0;
    logic signed [N-1:0]     Y = '0;
    logic                    co = 1'b0;
    logic                    out_ready = 1'b0;

    logic                    out_valid_a, out_co_a, out_ovf_a, err_overrun_a, busy_a;
    logic signed [ACC_W-1:0] out_data_a;
    logic                    out_valid_b, out_co_b, out_ovf_b, err_overrun_b, busy_b;
    logic signed [ACC_W-1:0] out_data_b;

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;

    logic signed [N-1:0] hy  [0:4095];
    logic                hco [0:4095];

    // Model state, index 0 = LEN_A instance, 1 = LEN_B instance.
    bit     iss[$];
    longint m_acc   [2];
    int     m_cnt   [2];
    bit     m_coa   [2];
    bit     m_ova   [2];
    bit     m_sv    [2];
    longint m_sdata [2];
    bit     m_sco   [2];
    bit     m_sovf  [2];
    bit     m_ovr   [2];

    datapath_result_accum #(.N(N), .PIPE(PIPE), .LEN(LEN_A), .ACC_W(ACC_W)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .Y           (Y),
        .co          (co),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready),
        .out_data    (out_data_a),
        .out_co      (out_co_a),
        .out_ovf     (out_ovf_a),
        .err_overrun (err_overrun_a),
        .busy        (busy_a)
    );

    datapath_result_accum #(.N(N), .PIPE(PIPE), .LEN(LEN_B), .ACC_W(ACC_W)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .Y           (Y),
        .co          (co),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready),
        .out_data    (out_data_b),
        .out_co      (out_co_b),
        .out_ovf     (out_ovf_b),
        .err_overrun (err_overrun_b),
        .busy        (busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'(t);
    endfunction

    task automatic model_inst(input int m, input bit res_v);
        int     len;
        longint s;
        bit     clamp;
        bit     win;
        bit     was_full;
        len      = (m == 0) ? LEN_A : LEN_B;
        was_full = m_sv[m];
        win      = 1'b0;
        clamp    = 1'b0;
        if (res_v) begin
            s = m_acc[m] + longint'(Y);
`ifdef DATAPATH_ACC_SAT_EN
            if (s > ACC_MAX) begin
                s = ACC_MAX;
                clamp = 1'b1;
            end else if (s < ACC_MIN) begin
                s = ACC_MIN;
                clamp = 1'b1;
            end
`endif
            if (m_cnt[m] == len - 1) begin
                win = 1'b1;
                if (!was_full || out_ready) begin
                    m_sv[m]    = 1'b1;
                    m_sdata[m] = wrap_acc(s);
                    m_sco[m]   = m_coa[m] | co;
                    m_sovf[m]  = m_ova[m] | clamp;
                end else begin
                    m_ovr[m] = 1'b1;
                end
                m_acc[m] = 0;
                m_cnt[m] = 0;
                m_coa[m] = 1'b0;
                m_ova[m] = 1'b0;
            end else begin
                m_acc[m] = s;
                m_cnt[m] = m_cnt[m] + 1;
                m_coa[m] = m_coa[m] | co;
                m_ova[m] = m_ova[m] | clamp;
            end
        end
        if (was_full && out_ready && !win) m_sv[m] = 1'b0;
    endtask

    task automatic model_edge();
        bit res_v;
        if (rst) begin
            iss.delete();
            for (int m = 0; m < 2; m++) begin
                m_acc[m] = 0; m_cnt[m] = 0; m_coa[m] = 0; m_ova[m] = 0;
                m_sv[m] = 0; m_sdata[m] = 0; m_sco[m] = 0; m_sovf[m] = 0; m_ovr[m] = 0;
            end
            return;
        end
        res_v = (iss.size() >= PIPE) ? iss[iss.size() - PIPE] : 1'b0;
        iss.push_back(issue_valid);
        for (int m = 0; m < 2; m++) model_inst(m, res_v);
    endtask

    task automatic compare_all();
        bit infl;
        infl = 1'b0;
        for (int i = 0; i < PIPE; i++) begin
            if (iss.size() > i && iss[iss.size() - 1 - i]) infl = 1'b1;
        end
        check("a.out_valid",   out_valid_a,   m_sv[0]);
        check("a.err_overrun", err_overrun_a, m_ovr[0]);
        check("a.busy",        busy_a,        (m_cnt[0] != 0) || infl);
        check("b.out_valid",   out_valid_b,   m_sv[1]);
        check("b.err_overrun", err_overrun_b, m_ovr[1]);
        check("b.busy",        busy_b,        (m_cnt[1] != 0) || infl);
        if (m_sv[0]) begin
            check("a.out_data", out_data_a, m_sdata[0]);
            check("a.out_co",   out_co_a,   m_sco[0]);
            check("a.out_ovf",  out_ovf_a,  m_sovf[0]);
        end
        if (m_sv[1]) begin
            check("b.out_data", out_data_b, m_sdata[1]);
            check("b.out_co",   out_co_b,   m_sco[1]);
            check("b.out_ovf",  out_ovf_b,  m_sovf[1]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    end

    // Each step drives one cycle; Y/co play the datapath, arriving PIPE steps after issue.
    task automatic step(input bit r, input bit iv, input logic signed [N-1:0] y, input bit c, input bit rdy);
        @(negedge clk);
        hy[cyc]     = y;
        hco[cyc]    = c;
        rst         = r;
        issue_valid = iv;
        out_ready   = rdy;
        if (cyc >= PIPE) begin
            Y  = hy[cyc - PIPE];
            co = hco[cyc - PIPE];
        end
        cyc++;
    endtask

    task automatic run_reset();
        step(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        run_reset();
        #1;
        check("rst a.out_valid", out_valid_a, 0);
        check("rst a.out_data",  out_data_a, 0);
        check("rst a.out_co",    out_co_a, 0);
        check("rst a.out_ovf",   out_ovf_a, 0);
        check("rst a.err_overrun", err_overrun_a, 0);
        check("rst a.busy",      busy_a, 0);
        check("rst b.busy",      busy_b, 0);

        // Basic window: 10+20+30-5 = 55, carry seen once
        run_reset();
        step(1'b0, 1'b1, 16'sd10, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'sd20, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'sd30, 1'b0, 1'b0);
        step(1'b0, 1'b1, -16'sd5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd999, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd999, 1'b0, 1'b0);
        #1;
        check("basic valid early", out_valid_a, 0);
        after_edge();
        check("basic valid", out_valid_a, 1);
        check("basic data",  out_data_a, 55);
        check("basic co",    out_co_a, 1);

        // LEN=32 of 32767: saturate or wrap
        run_reset();
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 16'sd32767, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b1);
        after_edge();
        check("big valid", out_valid_b, 1);
`ifdef DATAPATH_ACC_SAT_EN
        check("big data sat", out_data_b, 524287);
        check("big ovf sat",  out_ovf_b, 1);
`else
        check("big data wrap", out_data_b, -32);
        check("big ovf wrap",  out_ovf_b, 0);
`endif

        // Overrun: two windows of Y=1 with no consumer
        run_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'sd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
        after_edge();
        check("ovr err",   err_overrun_a, 1);
        check("ovr data",  out_data_a, 4);
        check("ovr valid", out_valid_a, 1);

        // Handshake on the same edge as the second window end reloads the slot
        run_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'sd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'sd2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b1);
        after_edge();
        check("reload valid", out_valid_a, 1);
        check("reload data",  out_data_a, 8);
        check("reload err",   err_overrun_a, 0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
        after_edge();
        check("reload hold", out_data_a, 8);

        // Reset mid-window with a result in flight
        run_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'sd100, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd999, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'sd999, 1'b0, 1'b0);
        #1;
        check("midrst busy", busy_a, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'sd3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
        after_edge();
        check("midrst valid", out_valid_a, 1);
        check("midrst data",  out_data_a, 12);

        // Bubbles: pattern 1,0,1,0,1,1 of Y=7, junk Y on bubbles
        run_reset();
        step(1'b0, 1'b1, 16'sd7, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd999, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'sd7, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd999, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'sd7, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'sd7, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
        #1;
        check("bubble busy pre", busy_a, 1);
        after_edge();
        check("bubble valid", out_valid_a, 1);
        check("bubble data",  out_data_a, 28);
        check("bubble co",    out_co_a, 0);
        check("bubble busy",  busy_a, 0);
        step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'sd0, 1'b0, 1'b0);
        #1;
        check("bubble single", out_valid_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
